// File: rtl/ps_intr_pkg.sv
// Shared defaults and helpers for the ps_intr_cnt_mc interrupt frame counter.
package ps_intr_pkg;

  localparam int CH_NUM_DEF     = 4;
  localparam int CNT_W_DEF      = 8;
  localparam int CNT_MAX_DEF    = 3;
  localparam int VALID_TIME_DEF = 10;
  localparam int TIME_W_DEF     = 8;

  // Channel-ID width; a single channel still needs one bit.
  function automatic int ch_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps_intr_cnt_mc_if.sv
// Interrupt-level / ack / status bundle of ps_intr_cnt_mc; master drives levels and acks.
interface ps_intr_cnt_mc_if
  import ps_intr_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic [CH_NUM-1:0]             cnt_en;
  logic [CH_NUM-1:0]             ack;
  logic [CH_NUM*CNT_W-1:0]       cnt_value;
  logic [CH_NUM-1:0]             frame_valid;
  logic [CH_NUM-1:0]             pending;
  logic                          irq;
  logic [ch_id_w(CH_NUM)-1:0]    ch_id;
  logic [CH_NUM-1:0]             ovf;

  modport master (output cnt_en, ack,
                  input  cnt_value, frame_valid, pending, irq, ch_id, ovf);
  modport slave  (input  cnt_en, ack,
                  output cnt_value, frame_valid, pending, irq, ch_id, ovf);
endinterface

// File: rtl/ps_intr_ch.sv
// One interrupt channel: 2-flop sync, high-time qualifier, wrapping frame counter, pending/overflow.
// Overflow tracking is built only when PS_INTR_OVF_EN is defined.
module ps_intr_ch
  import ps_intr_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int CNT_MAX    = CNT_MAX_DEF,
  parameter int VALID_TIME = VALID_TIME_DEF,
  parameter int TIME_W     = TIME_W_DEF
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             cnt_en,
  input  logic             ack,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_vld,
  output logic             pend,
  output logic             pend_nxt,
  output logic             ovf
);

  logic [1:0]        sync_q, sync_d;
  logic [TIME_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fv_q, fv_d;
  logic              pend_q, pend_d;
  logic              lvl, ev;

  assign lvl = sync_q[1];
  // hc saturates at VALID_TIME, so VALID_TIME-1 is crossed once per high period.
  assign ev  = lvl && (hc_q == TIME_W'(VALID_TIME - 1));

  always_comb begin
    sync_d = {sync_q[0], cnt_en};
    hc_d   = '0;
    if (lvl) hc_d = (hc_q == TIME_W'(VALID_TIME)) ? hc_q : hc_q + TIME_W'(1);
    cnt_d  = cnt_q;
    if (ev) cnt_d = (cnt_q == CNT_W'(CNT_MAX)) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    fv_d   = ev;
    pend_d = ev ? 1'b1 : (ack ? 1'b0 : pend_q);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q <= '0;
      hc_q   <= '0;
      cnt_q  <= '0;
      fv_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hc_q   <= hc_d;
      cnt_q  <= cnt_d;
      fv_q   <= fv_d;
      pend_q <= pend_d;
    end
  end

`ifdef PS_INTR_OVF_EN
  logic ovf_q, ovf_d;

  // An event landing on an already-pending or just-acked flag is a lost interrupt.
  always_comb begin
    ovf_d = ovf_q;
    if (ev && (pend_q || ack)) ovf_d = 1'b1;
    else if (ack)              ovf_d = 1'b0;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign cnt       = cnt_q;
  assign frame_vld = fv_q;
  assign pend      = pend_q;
  assign pend_nxt  = pend_d;

endmodule

// File: rtl/ps_intr_cnt_mc.sv
// Multi-channel interrupt frame counter: CH_NUM ps_intr_ch instances plus a lowest-index IRQ encoder.
// Optional overflow flags enabled by defining PS_INTR_OVF_EN.
module ps_intr_cnt_mc
  import ps_intr_pkg::*;
#(
  parameter int CH_NUM     = CH_NUM_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int CNT_MAX    = CNT_MAX_DEF,
  parameter int VALID_TIME = VALID_TIME_DEF,
  parameter int TIME_W     = TIME_W_DEF
) (
  input  logic                        I_Clk,
  input  logic                        I_Rst_n,
  input  logic [CH_NUM-1:0]           I_Cnt_En,
  input  logic [CH_NUM-1:0]           I_Ack,
  output logic [CH_NUM*CNT_W-1:0]     O_Cnt_Value,
  output logic [CH_NUM-1:0]           O_Frame_Valid,
  output logic [CH_NUM-1:0]           O_Pending,
  output logic                        O_Irq,
  output logic [ch_id_w(CH_NUM)-1:0]  O_Ch_Id,
  output logic [CH_NUM-1:0]           O_Ovf
);

  localparam int ID_W = ch_id_w(CH_NUM);

  logic [CH_NUM-1:0][CNT_W-1:0] cnt;
  logic [CH_NUM-1:0]            pend_nxt;
  logic                         irq_q, irq_d;
  logic [ID_W-1:0]              ch_id_q, ch_id_d;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    ps_intr_ch #(
      .CNT_W      (CNT_W),
      .CNT_MAX    (CNT_MAX),
      .VALID_TIME (VALID_TIME),
      .TIME_W     (TIME_W)
    ) u_ch (
      .gclk      (I_Clk),
      .grst_n    (I_Rst_n),
      .cnt_en    (I_Cnt_En[g]),
      .ack       (I_Ack[g]),
      .cnt       (cnt[g]),
      .frame_vld (O_Frame_Valid[g]),
      .pend      (O_Pending[g]),
      .pend_nxt  (pend_nxt[g]),
      .ovf       (O_Ovf[g])
    );
  end

  // Encode from next-state pending so IRQ/ID land in the same cycle as O_Pending.
  always_comb begin
    irq_d   = |pend_nxt;
    ch_id_d = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (pend_nxt[i]) ch_id_d = ID_W'(i);
    end
  end

  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      irq_q   <= 1'b0;
      ch_id_q <= '0;
    end else begin
      irq_q   <= irq_d;
      ch_id_q <= ch_id_d;
    end
  end

  assign O_Cnt_Value = cnt;
  assign O_Irq       = irq_q;
  assign O_Ch_Id     = ch_id_q;

endmodule

// File: tb/tb_ps_intr_cnt_mc.sv
// Directed bench for ps_intr_cnt_mc: model pushes expected pulses to a queue, a monitor pops them.
module tb_ps_intr_cnt_mc;
  import ps_intr_pkg::*;

  localparam int CH   = 4;
  localparam int CW   = 8;
  localparam int CMAX = 3;
  localparam int VT   = 10;
  localparam int TW   = 8;
  localparam int IDW  = ch_id_w(CH);
`ifdef PS_INTR_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps_intr_cnt_mc_if #(.CH_NUM(CH), .CNT_W(CW)) bus ();

  ps_intr_cnt_mc #(
    .CH_NUM(CH), .CNT_W(CW), .CNT_MAX(CMAX), .VALID_TIME(VT), .TIME_W(TW)
  ) dut (
    .I_Clk         (clk),
    .I_Rst_n       (rst_n),
    .I_Cnt_En      (bus.cnt_en),
    .I_Ack         (bus.ack),
    .O_Cnt_Value   (bus.cnt_value),
    .O_Frame_Valid (bus.frame_valid),
    .O_Pending     (bus.pending),
    .O_Irq         (bus.irq),
    .O_Ch_Id       (bus.ch_id),
    .O_Ovf         (bus.ovf)
  );

  typedef struct {
    int ch;
    int cyc;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [CH-1:0][CW-1:0] m_cnt;
  logic [CH-1:0]         m_pend;
  logic [CH-1:0]         m_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [CH-1:0] p);
    for (int i = 0; i < CH; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, ".pend"},  64'(bus.pending),   64'(m_pend));
    chk({tag, ".irq"},   64'(bus.irq),       64'(|m_pend));
    chk({tag, ".chid"},  64'(bus.ch_id),     64'(lowest(m_pend)));
    chk({tag, ".ovf"},   64'(bus.ovf),       64'(m_ovf));
    chk({tag, ".cnt"},   64'(bus.cnt_value), 64'(m_cnt));
  endtask

  // Model of an accepted event: wrap 1..CMAX, pending set, overflow on pending/ack collision.
  task automatic push_ev(input logic [CH-1:0] mask, input int at, input bit ack_same);
    for (int i = 0; i < CH; i++) begin
      if (mask[i]) begin
        m_cnt[i] = (m_cnt[i] == CW'(CMAX)) ? CW'(1) : m_cnt[i] + CW'(1);
        if (OVF && (m_pend[i] || ack_same)) m_ovf[i] = 1'b1;
        m_pend[i] = 1'b1;
        q.push_back('{i, at, int'(m_cnt[i])});
      end
    end
  endtask

  // Hold mask high for h sampling edges; optional ack timed to hit the acceptance cycle.
  task automatic pulse(input logic [CH-1:0] mask, input int h, input bit ack_same);
    int c;
    int n;
    @(negedge clk);
    c = cyc;
    bus.cnt_en = mask;
    if (h >= VT) push_ev(mask, c + VT + 2, ack_same);
    n = 0;
    while (n < h + 3 || n < VT + 4) begin
      @(negedge clk);
      n = cyc - c;
      if (n == h) bus.cnt_en = '0;
      bus.ack = (ack_same && n == VT + 1) ? mask : '0;
    end
  endtask

  task automatic do_ack(input logic [CH-1:0] mask);
    @(negedge clk);
    bus.ack = mask;
    @(negedge clk);
    bus.ack = '0;
    m_pend &= ~mask;
    m_ovf  &= ~mask;
  endtask

  // Every observed pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < CH; i++) begin
      if (bus.frame_valid[i] === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_pulse", 64'(bus.frame_valid[i]), 64'(0));
        end else begin
          e = q.pop_front();
          chk("pulse_ch",  64'(i),   64'(e.ch));
          chk("pulse_cyc", 64'(cyc), 64'(e.cyc));
          chk("pulse_cnt", 64'(bus.cnt_value[i*CW +: CW]), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    int c;
    bus.cnt_en = '0;
    bus.ack    = '0;
    m_cnt  = '0;
    m_pend = '0;
    m_ovf  = '0;

    repeat (3) @(negedge clk);
    chk_state("reset");
    chk("reset.fv", 64'(bus.frame_valid), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    pulse(4'b0001, 20, 1'b0);
    chk_state("ch0_first");
    pulse(4'b0010, 8, 1'b0);
    chk_state("ch1_short");
    pulse(4'b0010, VT - 1, 1'b0);
    chk_state("ch1_vt_m1");

    pulse(4'b0001, 12, 1'b0);
    chk_state("ch0_second");
    do_ack(4'b0001);
    chk_state("ch0_ack");

    repeat (4) pulse(4'b0100, 11, 1'b0);
    chk_state("ch2_wrap");
    do_ack(4'b0100);
    chk_state("ch2_ack");

    pulse(4'b1010, VT, 1'b0);
    chk_state("ch1_ch3");
    do_ack(4'b0010);
    chk_state("ack_ch1");
    do_ack(4'b1000);
    chk_state("ack_ch3");

    pulse(4'b0001, 15, 1'b1);
    chk_state("ev_and_ack");
    do_ack(4'b0001);
    chk_state("ev_and_ack_clr");

    // Reset in the middle of a high period; level stays high across release.
    @(negedge clk);
    bus.cnt_en = 4'b0001;
    repeat (5) @(negedge clk);
    rst_n  = 1'b0;
    m_cnt  = '0;
    m_pend = '0;
    m_ovf  = '0;
    @(negedge clk);
    chk_state("in_reset");
    chk("in_reset.fv", 64'(bus.frame_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    push_ev(4'b0001, c + VT + 2, 1'b0);
    repeat (VT + 4) @(negedge clk);
    bus.cnt_en = '0;
    repeat (3) @(negedge clk);
    chk_state("post_reset");

    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps_intr_cnt_mc.md
PS_INTR_CNT_MC -- requirements
Module: ps_intr_cnt_mc

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default, meaning:
- CH_NUM, 4, number of independent interrupt channels (1..16)
- CNT_W, 8, width of each frame counter
- CNT_MAX, 3, counter wrap value (1..2^CNT_W-1)
- VALID_TIME, 10, synchronised high cycles required to accept an event (1..2^TIME_W-1)
- TIME_W, 8, width of the per-channel high-time counter
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- I_Clk, in, 1, single clock
- I_Rst_n, in, 1, reset, asynchronous, active-low
- I_Cnt_En, in, CH_NUM, asynchronous interrupt levels, one bit per channel
- I_Ack, in, CH_NUM, pending-clear strobes, one bit per channel
- O_Cnt_Value, out, CH_NUM*CNT_W, frame counters; channel n occupies bits [n*CNT_W +: CNT_W]
- O_Frame_Valid, out, CH_NUM, one-cycle accepted-event pulses
- O_Pending, out, CH_NUM, sticky event flags
- O_Irq, out, 1, OR of O_Pending
- O_Ch_Id, out, clog2(CH_NUM) (minimum 1), lowest-index pending channel
- O_Ovf, out, CH_NUM, sticky overflow flags

Function
REQ-003 Each I_Cnt_En bit SHALL pass through a two-flop synchroniser; the second flop's output is the channel's sync level.
REQ-004 Each channel's high-time counter SHALL clear when sync level is 0, and SHALL increment when sync level is 1, saturating at VALID_TIME.
REQ-005 A channel SHALL accept an event in the cycle where sync level is 1 and the high-time counter equals VALID_TIME-1; each high period yields at most one event.
REQ-006 A high period shorter than VALID_TIME sync cycles SHALL produce no event and no state change.
REQ-007 On an accepted event, O_Frame_Valid[n] SHALL be 1 for exactly the following cycle; input sampled high at edge k gives the pulse after edge k+VALID_TIME+1.
REQ-008 On an accepted event, counter n SHALL increment, wrapping CNT_MAX to 1, with the update in the same cycle as the pulse; 0 occurs only after reset.
REQ-009 On an accepted event, O_Pending[n] SHALL set; I_Ack[n]=1 SHALL clear it next cycle; an event and an ack in the same cycle leave O_Pending[n]=1.
REQ-010 O_Irq and O_Ch_Id SHALL be registered from the next-state pending vector, so they align with O_Pending; with no channel pending, O_Ch_Id=0.
REQ-011 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be recorded.

Reset
REQ-012 While I_Rst_n=0, all synchroniser flops, high-time counters, O_Cnt_Value, O_Frame_Valid, O_Pending, O_Irq, O_Ch_Id and O_Ovf SHALL be 0.
REQ-013 Reset asserted mid-high-period SHALL discard the period; after release, a level already high SHALL need a full VALID_TIME count from sync before it is accepted.

Configuration
REQ-014 With PS_INTR_OVF_EN defined:
- an event on a channel whose O_Pending is already 1 SHALL set O_Ovf[n];
- I_Ack[n] SHALL clear O_Ovf[n];
- an event with a simultaneous ack SHALL set O_Ovf[n].
REQ-015 Without PS_INTR_OVF_EN, O_Ovf SHALL be constant 0 and no overflow logic SHALL be present.

Structure
REQ-016 Package ps_intr_pkg SHALL hold the parameter defaults and a clog2-based channel-ID width function.
REQ-017 Sub-module ps_intr_ch SHALL contain one channel (synchroniser, high-time counter, frame counter, pending and overflow flags); the top generates CH_NUM instances plus the priority encoder.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Ch0 high 20 cycles, VALID_TIME=10 -> one pulse after edge 11; O_Cnt_Value[0]=1; O_Pending[0]=1; O_Irq=1; O_Ch_Id=0.
- Ch1 high 8 cycles -> no pulse; counter 0; pending 0.
- Four accepted events on ch2 with CNT_MAX=3 -> counter 1,2,3,1.
- Ch3 and ch1 events in the same cycle -> both pending; O_Ch_Id=1; ack ch1 -> O_Ch_Id=3; ack ch3 -> O_Irq=0.
- Second ch0 event without ack, macro on -> O_Ovf[0]=1; ack -> O_Pending[0]=0 and O_Ovf[0]=0; macro off -> O_Ovf stays 0.
- Reset pulsed 5 cycles into a ch0 high period, level held -> all outputs 0; pulse after edge VALID_TIME+1 counted from release.
